// File: rtl/mips_pipeline_pkg.sv
// Shared definitions for the MIPS pipeline sequencing logic.
// State encoding, register-zero constant and drain default.
package mips_pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEFAULT_DRAIN_CYCLES = 3;

endpackage

// File: rtl/saturating_counter.sv
// Event counter that sticks at all ones instead of wrapping.
// Used for the stall and redirect statistics.
module saturating_counter #(
  parameter int N_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  output logic [N_BITS-1:0] count_o
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + N_BITS'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use stall, redirect squash and debug halt/step sequencing
// for the five-stage MIPS pipeline.
module pipeline_hazard_controller
  import mips_pipeline_pkg::*;
#(
  parameter int COUNT_WIDTH  = 16,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             ID_rs_i,
  input  logic [4:0]             ID_rt_i,
  input  logic                   ID_uses_rt_i,
  input  logic [4:0]             EX_rt_i,
  input  logic                   EX_mem_read_i,
  input  logic                   MEM_redirect_i,
  input  logic                   halt_req_i,
  input  logic                   step_i,
  output logic                   pc_write_o,
  output logic                   if_id_write_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_flush_o,
  output logic                   ex_mem_flush_o,
  output logic                   halted_o,
  output logic [COUNT_WIDTH-1:0] stall_count_o,
  output logic [COUNT_WIDTH-1:0] flush_count_o
);

  // Counter holds remaining cycles minus one, so the
  // step load of DRAIN_CYCLES still fits the same width.
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e        state;
  logic [DW-1:0] drain_cnt;
  logic          lu;
  logic          stall_inc;
  logic          flush_inc;

  assign lu = EX_mem_read_i
            & (EX_rt_i != REG_ZERO)
            & ((EX_rt_i == ID_rs_i)
               | (ID_uses_rt_i & (EX_rt_i == ID_rt_i)));

  assign halted_o = (state == ST_HALTED);

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (MEM_redirect_i) begin
          if_id_flush_o  = 1'b1;
          id_ex_flush_o  = 1'b1;
          ex_mem_flush_o = 1'b1;
          flush_inc      = 1'b1;
        end else if (lu) begin
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          id_ex_flush_o = 1'b1;
          stall_inc     = 1'b1;
        end else if (halt_req_i) begin
          pc_write_o    = 1'b0;
          if_id_flush_o = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (MEM_redirect_i) begin
          if_id_flush_o  = 1'b1;
          id_ex_flush_o  = 1'b1;
          ex_mem_flush_o = 1'b1;
          flush_inc      = 1'b1;
        end else begin
          pc_write_o    = 1'b0;
          if_id_flush_o = 1'b1;
        end
      end
      ST_HALTED: begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        id_ex_flush_o = 1'b1;
      end
      ST_STEP: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (!MEM_redirect_i && !lu && halt_req_i) begin
            state     <= ST_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_HALTED;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        ST_HALTED: begin
          if (!halt_req_i) begin
            state <= ST_RUN;
          end else if (step_i) begin
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          state     <= ST_DRAIN;
          drain_cnt <= DW'(DRAIN_CYCLES);
        end
      endcase
    end
  end

  saturating_counter #(
    .N_BITS (COUNT_WIDTH)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stall_inc),
    .count_o (stall_count_o)
  );

  saturating_counter #(
    .N_BITS (COUNT_WIDTH)
  ) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (flush_inc),
    .count_o (flush_count_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with an
// expected-result queue checked at each falling edge.
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  ex_rt;
  logic        ex_mem_read;
  logic        mem_redirect;
  logic        halt_req;
  logic        step;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        halted;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  pipeline_hazard_controller #(
    .COUNT_WIDTH  (16),
    .DRAIN_CYCLES (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_rs_i        (id_rs),
    .ID_rt_i        (id_rt),
    .ID_uses_rt_i   (id_uses_rt),
    .EX_rt_i        (ex_rt),
    .EX_mem_read_i  (ex_mem_read),
    .MEM_redirect_i (mem_redirect),
    .halt_req_i     (halt_req),
    .step_i         (step),
    .pc_write_o     (pc_write),
    .if_id_write_o  (if_id_write),
    .if_id_flush_o  (if_id_flush),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_flush_o (ex_mem_flush),
    .halted_o       (halted),
    .stall_count_o  (stall_count),
    .flush_count_o  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {pc_write, if_id_write, if_id_flush,
  //        id_ex_flush, ex_mem_flush, halted}
  localparam logic [5:0] C_DEF   = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_SQSH  = 6'b111110;
  localparam logic [5:0] C_DRAIN = 6'b011000;
  localparam logic [5:0] C_HALT  = 6'b000101;

  typedef struct {
    string       tag;
    logic [5:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          passed;
  logic [15:0] es;
  logic [15:0] ef;

  task automatic compare();
    exp_t       e;
    logic [5:0] ctl;
    e   = sb.pop_front();
    ctl = {pc_write, if_id_write, if_id_flush,
           id_ex_flush, ex_mem_flush, halted};
    total++;
    assert (ctl === e.ctl) passed++;
    else $error("FAIL %s ctl got %b want %b", e.tag, ctl, e.ctl);
    total++;
    assert (stall_count === e.sc) passed++;
    else $error("FAIL %s stall_count got %h want %h",
                e.tag, stall_count, e.sc);
    total++;
    assert (flush_count === e.fc) passed++;
    else $error("FAIL %s flush_count got %h want %h",
                e.tag, flush_count, e.fc);
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic cyc(input string tag, input logic [5:0] ctl);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.sc  = es;
    e.fc  = ef;
    sb.push_back(e);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    id_uses_rt   = 1'b0;
    ex_rt        = 5'd0;
    ex_mem_read  = 1'b0;
    mem_redirect = 1'b0;
    halt_req     = 1'b0;
    step         = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    es     = 16'd0;
    ef     = 16'd0;
    reset  = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", C_DEF);
    reset = 1'b1;
    cyc("run_idle", C_DEF);

    // lw $t0 in EX, add using $t0 as rs in ID
    ex_rt = 5'd8; ex_mem_read = 1'b1; id_rs = 5'd8;
    cyc("lu_rs", C_STALL);
    es++;
    ex_mem_read = 1'b0;
    cyc("lu_after", C_DEF);

    ex_rt = 5'd0; id_rs = 5'd0; ex_mem_read = 1'b1;
    cyc("lu_rzero", C_DEF);
    ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
    cyc("lu_rt_unused", C_DEF);
    id_uses_rt = 1'b1;
    cyc("lu_rt_used", C_STALL);
    es++;
    ex_mem_read = 1'b0;
    cyc("lu_rt_after", C_DEF);

    // redirect with a simultaneous load-use
    ex_mem_read = 1'b1; mem_redirect = 1'b1;
    cyc("redir_lu", C_SQSH);
    ef++;
    idle_inputs();
    cyc("redir_after", C_DEF);

    // halt, hold, release
    halt_req = 1'b1;
    cyc("halt_acc", C_DRAIN);
    cyc("drain1", C_DRAIN);
    cyc("drain2", C_DRAIN);
    cyc("drain3", C_DRAIN);
    cyc("halted", C_HALT);
    cyc("halted_hold", C_HALT);
    halt_req = 1'b0;
    cyc("halted_rel", C_HALT);
    cyc("run_again", C_DEF);

    // halt with a redirect resolving mid-drain, then step
    halt_req = 1'b1;
    cyc("h2_acc", C_DRAIN);
    cyc("h2_drain1", C_DRAIN);
    mem_redirect = 1'b1;
    cyc("h2_redir", C_SQSH);
    ef++;
    mem_redirect = 1'b0;
    cyc("h2_drain3", C_DRAIN);
    cyc("h2_halted", C_HALT);
    step = 1'b1;
    cyc("step_pulse", C_HALT);
    step = 1'b0;
    cyc("step_fetch", C_DEF);
    cyc("step_d1", C_DRAIN);
    cyc("step_d2", C_DRAIN);
    cyc("step_d3", C_DRAIN);
    cyc("step_d4", C_DRAIN);
    cyc("step_halted", C_HALT);

    // release beats step in the same cycle
    halt_req = 1'b0; step = 1'b1;
    cyc("rel_vs_step", C_HALT);
    step = 1'b0;
    cyc("rel_run", C_DEF);

    // asynchronous reset in the middle of a drain
    halt_req = 1'b1;
    cyc("h3_acc", C_DRAIN);
    cyc("h3_drain1", C_DRAIN);
    halt_req = 1'b0;
    reset = 1'b0;
    es = 16'd0;
    ef = 16'd0;
    cyc("rst_mid_drain", C_DEF);
    reset = 1'b1;
    cyc("rst_run", C_DEF);

    // continuous load-use to saturate the stall counter
    ex_rt = 5'd8; id_rs = 5'd8; ex_mem_read = 1'b1;
    repeat (65539) @(posedge clk);
    #1;
    es = 16'hFFFF;
    cyc("sat", C_STALL);
    cyc("sat_hold", C_STALL);
    idle_inputs();
    cyc("sat_idle", C_DEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
